cpu_clock_controller: RTL and testbench
=======================================

// Module: cpu_clock_controller
// PURPOSE
//  Run/step/halt sequencer for the single-cycle CPU on Nexys 4 DDR. One board clock; emits one-cycle
//  clock-enable pulses (cpu_en) at a fast or slow rate, or one per debounced step press. Freezes on CPU
//  halt (syscall). Replaces the free-running divided clock with a single-domain enable scheme.
// PARAMETERS
//  FAST_DIV         2        board cycles per cpu_en in fast mode (>=1)
//  SLOW_DIV         1000000  board cycles per cpu_en in slow mode (>=1)
//  DEBOUNCE_CYCLES  100000   cycles a synced button level must be stable before it is accepted (>=1)
// PORTS
//  clk        in   1   board clock; all logic on posedge
//  rst_n      in   1   synchronous reset, active-low
//  frequency  in   1   1 = FAST_DIV rate, 0 = SLOW_DIV rate (async switch; 2-flop synced)
//  run_sw     in   1   1 = free-run requested (async switch; 2-flop synced)
//  step_btn   in   1   single-step button (async; synced + debounced)
//  go_btn     in   1   resume-from-halt button (async; synced + debounced)
//  cpu_halt   in   1   CPU halt request, synchronous to clk
//  cpu_en     out  1   CPU clock enable, one-cycle pulses, registered
//  state      out  2   FSM state: 00 IDLE, 01 RUN, 10 STEP, 11 HALTED
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state=IDLE, cpu_en=0, rate counter=0, sync/debounce flops=0, cycle_cnt=0.
//  Rate counter: DIV = frequency_s ? FAST_DIV : SLOW_DIV. tick = (cnt >= DIV-1); on tick cnt<=0 else cnt+1.
//   Counts in every state; `>=` guarantees wrap when frequency switches mid-count to a smaller DIV.
//   Counter width = $clog2(max(FAST_DIV,SLOW_DIV))+1.
//  Debounce (per button): after sync, level accepted when unchanged DEBOUNCE_CYCLES consecutive cycles;
//   accepted 0->1 gives one-cycle step_p / go_p on the next cycle. Holding a button = one pulse.
//  FSM (evaluated each cycle; priority top-down within each state):
//   IDLE:   cpu_halt -> HALTED; run_sw_s -> RUN; step_p -> STEP; else stay.
//   RUN:    cpu_halt -> HALTED; !run_sw_s -> IDLE; else stay. step_p ignored.
//   STEP:   -> IDLE unconditionally (state held exactly one cycle).
//   HALTED: go_p -> IDLE; else stay. step_p, run_sw_s ignored.
//  cpu_en (registered, next cycle): 1 when (state==RUN && tick && !cpu_halt), or state==STEP,
//   or (state==HALTED && go_p) -> single release pulse so CPU retires the halting instruction. Else 0.
//  cpu_halt and tick in same RUN cycle: halt wins, no pulse. run_sw drop and tick same cycle: no pulse.
//  cpu_en never high two consecutive cycles when FAST_DIV>=2; FAST_DIV=1 gives cpu_en=1 every cycle in RUN.
//  Reset mid-run/mid-step: any pending pulse discarded, cpu_en=0 the cycle after reset sampled.
//  Step latency from clean step_btn rise (IDLE): 2 sync + DEBOUNCE_CYCLES + 1 edge + 1 FSM -> cpu_en.
// CONFIGURATION
//  CYCLE_COUNTER_EN defined: adds output port cycle_cnt [31:0] = count of cpu_en pulses since reset,
//   increments the cycle after each cpu_en=1, wraps 0xFFFFFFFF->0, cleared only by reset. For 7-seg display.
//  CYCLE_COUNTER_EN undefined: port and counter absent; all other behaviour identical.
// TESTING (bench params FAST_DIV=2, SLOW_DIV=5, DEBOUNCE_CYCLES=4)
//  Reset 3 cycles, run_sw=1, frequency=1 -> state=01 after sync, cpu_en pulses every 2nd cycle, 10 pulses/20 cyc.
//  frequency 1->0 while running -> pulses every 5th cycle; 0->1 with cnt=4 -> wrap and pulse within 1 cycle.
//  run_sw=0, step_btn high 10 cycles with 1-cycle glitch before -> exactly one cpu_en, state 10 for 1 cycle then 00.
//  step_btn bounces 0/1 every 2 cycles for 20 cycles -> no cpu_en until stable 4 cycles, then exactly one.
//  RUN, assert cpu_halt on tick cycle -> no pulse, state=11; go_btn press -> one cpu_en, state=00; run_sw=1 -> RUN.
//  Define CYCLE_COUNTER_EN, 7 steps + 13 run pulses -> cycle_cnt=20; rst_n=0 one cycle -> cycle_cnt=0, cpu_en=0.

Source files
------------

// File: rtl/cpu_clock_controller.sv
// cpu_clock_controller: run/step/halt sequencer emitting one-cycle CPU clock-enable pulses.
// Latency: cpu_en registered; step press -> cpu_en after 2 sync + DEBOUNCE_CYCLES + 1 edge + 1 FSM cycles.
// Backpressure: none; cpu_halt freezes pulses until a debounced go press. Macro CYCLE_COUNTER_EN adds cycle_cnt.
module cpu_clock_controller #(
  parameter int FAST_DIV        = 2,
  parameter int SLOW_DIV        = 1000000,
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frequency,
  input  logic        run_sw,
  input  logic        step_btn,
  input  logic        go_btn,
  input  logic        cpu_halt,
  output logic        cpu_en,
  output logic [1:0]  state
`ifdef CYCLE_COUNTER_EN
  ,
  output logic [31:0] cycle_cnt
`endif
);

  // Rate counter is sized for the larger divider plus one bit of headroom.
  localparam int MAX_DIV = (FAST_DIV > SLOW_DIV) ? FAST_DIV : SLOW_DIV;
  localparam int CW      = $clog2(MAX_DIV) + 1;
  localparam logic [CW-1:0] FAST_LAST = CW'(FAST_DIV - 1);
  localparam logic [CW-1:0] SLOW_LAST = CW'(SLOW_DIV - 1);

  localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

  // Bit positions of the asynchronous inputs inside the synchronizer vectors.
  localparam int I_FREQ = 0;
  localparam int I_RUN  = 1;
  localparam int I_STEP = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    STEP   = 2'b10,
    HALTED = 2'b11
  } state_t;

  state_t          fsm;
  logic [3:0]      meta;
  logic [3:0]      sync;
  logic            frequency_s;
  logic            run_sw_s;
  logic [CW-1:0]   rate_cnt;
  logic [CW-1:0]   div_last;
  logic            tick;
  logic [1:0]      db_level;
  logic [DW-1:0]   db_cnt [2];
  logic [1:0]      db_rise;
  logic            step_p;
  logic            go_p;

  assign frequency_s = sync[I_FREQ];
  assign run_sw_s    = sync[I_RUN];
  assign step_p      = db_rise[0];
  assign go_p        = db_rise[1];
  assign state       = fsm;

  // Two-flop synchronizers for the switches and buttons.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= '0;
      sync <= '0;
    end else begin
      meta <= {go_btn, step_btn, run_sw, frequency};
      sync <= meta;
    end
  end

  // Free-running rate counter; >= lets a mid-count switch to a smaller divider wrap at once.
  assign div_last = frequency_s ? FAST_LAST : SLOW_LAST;
  assign tick     = (rate_cnt >= div_last);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rate_cnt <= '0;
    end else if (tick) begin
      rate_cnt <= '0;
    end else begin
      rate_cnt <= rate_cnt + 1'b1;
    end
  end

  // Debounce step (index 0) and go (index 1): accept a new level after it differs from the
  // accepted one for DEBOUNCE_CYCLES consecutive cycles; an accepted rise gives a one-cycle pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      db_level <= '0;
      db_rise  <= '0;
      for (int i = 0; i < 2; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync[I_STEP + i] == db_level[i]) begin
          db_cnt[i]  <= '0;
          db_rise[i] <= 1'b0;
        end else if (db_cnt[i] >= DB_LAST) begin
          db_cnt[i]   <= '0;
          db_level[i] <= sync[I_STEP + i];
          db_rise[i]  <= sync[I_STEP + i];
        end else begin
          db_cnt[i]  <= db_cnt[i] + 1'b1;
          db_rise[i] <= 1'b0;
        end
      end
    end
  end

  // Sequencer FSM with registered cpu_en; halt beats a coincident tick, as does a run_sw drop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm    <= IDLE;
      cpu_en <= 1'b0;
    end else begin
      case (fsm)
        IDLE: begin
          cpu_en <= 1'b0;
          if (cpu_halt) begin
            fsm <= HALTED;
          end else if (run_sw_s) begin
            fsm <= RUN;
          end else if (step_p) begin
            fsm <= STEP;
          end
        end
        RUN: begin
          cpu_en <= tick && !cpu_halt && run_sw_s;
          if (cpu_halt) begin
            fsm <= HALTED;
          end else if (!run_sw_s) begin
            fsm <= IDLE;
          end
        end
        STEP: begin
          cpu_en <= 1'b1;
          fsm    <= IDLE;
        end
        HALTED: begin
          // The go release pulse lets the CPU retire the instruction that halted it.
          cpu_en <= go_p;
          if (go_p) begin
            fsm <= IDLE;
          end
        end
        default: begin
          cpu_en <= 1'b0;
          fsm    <= IDLE;
        end
      endcase
    end
  end

`ifdef CYCLE_COUNTER_EN
  // Count of enable pulses since reset, for the 7-segment display; wraps naturally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cycle_cnt <= '0;
    end else if (cpu_en) begin
      cycle_cnt <= cycle_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cpu_clock_controller.sv
// tb_cpu_clock_controller: directed scenarios plus randomized inputs against a behavioural model.
// Model is updated at posedge from pre-edge inputs; DUT outputs compared at every negedge.
// Scenario checks read outputs 1 time unit after the posedge.
module tb_cpu_clock_controller;

  localparam int FAST = 2;
  localparam int SLOW = 5;
  localparam int DB   = 4;

  logic       clk;
  logic       rst_n;
  logic       frequency;
  logic       run_sw;
  logic       step_btn;
  logic       go_btn;
  logic       cpu_halt;
  logic       cpu_en;
  logic [1:0] state;
`ifdef CYCLE_COUNTER_EN
  logic [31:0] cycle_cnt;
`endif

  int n_chk;
  int n_fail;
  int pulses;
  int step_cycles;

  cpu_clock_controller #(
    .FAST_DIV(FAST),
    .SLOW_DIV(SLOW),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .frequency(frequency),
    .run_sw(run_sw),
    .step_btn(step_btn),
    .go_btn(go_btn),
    .cpu_halt(cpu_halt),
    .cpu_en(cpu_en),
    .state(state)
`ifdef CYCLE_COUNTER_EN
    ,
    .cycle_cnt(cycle_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- behavioural model ----------------
  bit           m_valid;
  bit [3:0]     m_s1;
  bit [3:0]     m_s2;
  int           m_cnt;
  int           m_state;
  bit           m_en;
  bit [1:0]     m_rise;
  bit [1:0]     m_level;
  bit           hist [2][DB];
  int           n_obs;
  int unsigned  m_cyc;

  function automatic bit m_tick_next();
    int div;
    div = m_s2[0] ? FAST : SLOW;
    return (m_cnt >= div - 1);
  endfunction

  always @(posedge clk) begin
    bit run_s;
    bit tk;
    bit all_same;
    bit raw;
    int ns;
    bit ne;
    bit [1:0] nr;
    if (!rst_n) begin
      m_valid = 1'b1;
      m_s1 = '0; m_s2 = '0; m_cnt = 0; m_state = 0; m_en = 1'b0;
      m_rise = '0; m_level = '0; n_obs = 0; m_cyc = 0;
      for (int b = 0; b < 2; b++)
        for (int k = 0; k < DB; k++) hist[b][k] = 1'b0;
    end else begin
      run_s = m_s2[1];
      tk = m_tick_next();
      ns = m_state;
      ne = 1'b0;
      case (m_state)
        0: begin
          if (cpu_halt) ns = 3;
          else if (run_s) ns = 1;
          else if (m_rise[0]) ns = 2;
        end
        1: begin
          ne = tk && !cpu_halt && run_s;
          if (cpu_halt) ns = 3;
          else if (!run_s) ns = 0;
        end
        2: begin
          ne = 1'b1;
          ns = 0;
        end
        default: begin
          ne = m_rise[1];
          if (m_rise[1]) ns = 0;
        end
      endcase
      if (m_en) m_cyc = m_cyc + 1;
      m_cnt = tk ? 0 : m_cnt + 1;
      // A button level is accepted once the last DB synced samples all show the new level.
      nr = '0;
      if (n_obs < DB) n_obs = n_obs + 1;
      for (int b = 0; b < 2; b++) begin
        raw = m_s2[b + 2];
        for (int k = DB - 1; k > 0; k--) hist[b][k] = hist[b][k - 1];
        hist[b][0] = raw;
        all_same = 1'b1;
        for (int k = 0; k < DB; k++) if (hist[b][k] != raw) all_same = 1'b0;
        if (n_obs >= DB && all_same && raw != m_level[b]) begin
          m_level[b] = raw;
          nr[b] = raw;
        end
      end
      m_s2 = m_s1;
      m_s1 = {go_btn, step_btn, run_sw, frequency};
      m_state = ns;
      m_en = ne;
      m_rise = nr;
    end
  end

  // Per-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      n_chk++;
      if (cpu_en !== m_en || state !== 2'(m_state)) begin
        n_fail++;
        $display("FAIL model_cmp t=%0t got cpu_en=%b state=%b expected cpu_en=%b state=%0d",
                 $time, cpu_en, state, m_en, m_state);
      end
`ifdef CYCLE_COUNTER_EN
      n_chk++;
      if (cycle_cnt !== m_cyc) begin
        n_fail++;
        $display("FAIL model_cycle_cnt t=%0t got %0d expected %0d", $time, cycle_cnt, m_cyc);
      end
`endif
    end
  end

  // Pulse and STEP-state tallies used by the scenario checks.
  always @(negedge clk) begin
    if (cpu_en === 1'b1) pulses++;
    if (state === 2'b10) step_cycles++;
  end

  // ---------------- helpers ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic press(input bit is_go, input int hi, input int lo);
    if (is_go) go_btn = 1'b1; else step_btn = 1'b1;
    cyc(hi);
    if (is_go) go_btn = 1'b0; else step_btn = 1'b0;
    cyc(lo);
  endtask

  task automatic wait_tick();
    for (int i = 0; i < 20; i++) begin
      if (m_tick_next()) break;
      cyc(1);
    end
    chk("wait_tick_bound", 32'(m_tick_next()), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int p0;
    int s0;
    n_chk = 0; n_fail = 0; pulses = 0; step_cycles = 0;
    rst_n = 1'b0; frequency = 1'b0; run_sw = 1'b0; step_btn = 1'b0;
    go_btn = 1'b0; cpu_halt = 1'b0;
    cyc(3);
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_cpu_en", 32'(cpu_en), 32'd0);

    // Fast free-run.
    rst_n = 1'b1; run_sw = 1'b1; frequency = 1'b1;
    cyc(6);
    chk("run_state", 32'(state), 32'd1);
    p0 = pulses; cyc(20);
    chk("fast_pulses_20", 32'(pulses - p0), 32'd10);

    // Slow rate, then back to fast.
    frequency = 1'b0; cyc(10);
    p0 = pulses; cyc(25);
    chk("slow_pulses_25", 32'(pulses - p0), 32'd5);
    frequency = 1'b1;
    p0 = pulses; cyc(6);
    chk("fast_return_pulse", 32'(pulses > p0), 32'd1);

    // Single step with a one-cycle glitch ahead of a clean press.
    run_sw = 1'b0; cyc(6);
    chk("idle_state", 32'(state), 32'd0);
    p0 = pulses; s0 = step_cycles;
    step_btn = 1'b1; cyc(1);
    step_btn = 1'b0; cyc(1);
    step_btn = 1'b1; cyc(7);
    chk("step_state_at_7", 32'(state), 32'd2);
    chk("step_en_at_7", 32'(cpu_en), 32'd0);
    cyc(1);
    chk("step_state_at_8", 32'(state), 32'd0);
    chk("step_en_at_8", 32'(cpu_en), 32'd1);
    cyc(2);
    step_btn = 1'b0; cyc(10);
    chk("step_glitch_pulses", 32'(pulses - p0), 32'd1);
    chk("step_glitch_step_cycles", 32'(step_cycles - s0), 32'd1);

    // Bouncing button: nothing until it holds steady.
    p0 = pulses;
    for (int i = 0; i < 5; i++) begin
      step_btn = 1'b1; cyc(2);
      step_btn = 1'b0; cyc(2);
    end
    cyc(6);
    chk("bounce_no_pulse", 32'(pulses - p0), 32'd0);
    step_btn = 1'b1; cyc(12);
    step_btn = 1'b0; cyc(10);
    chk("bounce_then_one", 32'(pulses - p0), 32'd1);

    // Halt on a tick cycle, release with go.
    run_sw = 1'b1; frequency = 1'b1; cyc(6);
    chk("halt_pre_run", 32'(state), 32'd1);
    wait_tick();
    cpu_halt = 1'b1; cyc(1);
    cpu_halt = 1'b0;
    chk("halt_no_pulse", 32'(cpu_en), 32'd0);
    chk("halt_state", 32'(state), 32'd3);
    run_sw = 1'b0;
    p0 = pulses; cyc(5);
    chk("halted_frozen", 32'(pulses - p0), 32'd0);
    press(1'b1, 10, 10);
    chk("go_release_pulse", 32'(pulses - p0), 32'd1);
    chk("go_state_idle", 32'(state), 32'd0);
    run_sw = 1'b1; cyc(5);
    chk("go_then_run", 32'(state), 32'd1);

    // Reset while a run pulse is due.
    wait_tick();
    rst_n = 1'b0; cyc(1);
    chk("midrun_reset_en", 32'(cpu_en), 32'd0);
    chk("midrun_reset_state", 32'(state), 32'd0);
    rst_n = 1'b1; run_sw = 1'b0; cyc(4);

    // Randomized inputs, checked every cycle by the model.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(49) == 0) frequency = ~frequency;
      if ($urandom_range(39) == 0) run_sw = ~run_sw;
      if ($urandom_range(4) == 0) step_btn = ~step_btn;
      if ($urandom_range(4) == 0) go_btn = ~go_btn;
      cpu_halt = ($urandom_range(39) == 0);
      rst_n = ($urandom_range(599) != 0);
      cyc(1);
    end

    // 7 steps then 13 slow run pulses.
    rst_n = 1'b0; frequency = 1'b0; run_sw = 1'b0; step_btn = 1'b0;
    go_btn = 1'b0; cpu_halt = 1'b0;
    cyc(2);
    rst_n = 1'b1; cyc(4);
    p0 = pulses;
    for (int i = 0; i < 7; i++) press(1'b0, 6, 8);
    chk("seven_steps", 32'(pulses - p0), 32'd7);
    run_sw = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (pulses - p0 >= 20) break;
      cyc(1);
    end
    run_sw = 1'b0;
    cyc(8);
    chk("twenty_pulses", 32'(pulses - p0), 32'd20);
`ifdef CYCLE_COUNTER_EN
    chk("cycle_cnt_20", cycle_cnt, 32'd20);
    rst_n = 1'b0; cyc(1);
    chk("cycle_cnt_reset", cycle_cnt, 32'd0);
    chk("cycle_cnt_reset_en", 32'(cpu_en), 32'd0);
    rst_n = 1'b1; cyc(2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
